// File: rtl/md_ctrl_if.sv
// md_ctrl_if -- handshake/operand bundle between the HI/LO controller and
// the iterative multiply/divide unit.
//   master: controller side (drives start/op/operands, receives result)
//   slave : multiply/divide unit side
interface md_ctrl_if;
  logic        md_start;   // held high for the whole operation
  logic        md_div;     // 1 = divide, 0 = multiply
  logic        md_signed;  // 1 = signed operands
  logic [31:0] md_x;       // multiplicand / dividend
  logic [31:0] md_y;       // multiplier / divisor
  logic [63:0] md_result;  // {HI,LO}; divide gives {remainder, quotient}
  logic        md_ready;   // result valid, held until md_start drops

  modport master (
    output md_start, md_div, md_signed, md_x, md_y,
    input  md_result, md_ready
  );

  modport slave (
    input  md_start, md_div, md_signed, md_x, md_y,
    output md_result, md_ready
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl -- MIPS-style HI/LO controller for an external iterative
// multiply/divide unit. Issues MULT/MULTU/DIV/DIVU, stalls the front of the
// pipeline while the unit works, writes HI/LO on completion, handles
// MTHI/MTLO and abandons results on a pipeline flush while still completing
// the unit's ready handshake.
// Optional feature: define HILO_FWD_EN to forward the HI/LO value being
// written in the current cycle straight to hi_o/lo_o (and drop the MFHI/MFLO
// stall in DRAIN).
module md_ctrl #(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_rd,
  input  logic        flush,
  md_ctrl_if.master   md,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q;
  logic        start_q;
  logic        div_q;
  logic        signed_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_md_s;
  logic        is_mt_s;
  logic        issue_s;
  logic        cap_s;
  logic        hi_wr_s;
  logic        lo_wr_s;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  assign is_md_s = (op == OP_MULT) || (op == OP_MULTU) ||
                   (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt_s = (op == OP_MTHI) || (op == OP_MTLO);

  // A new unit operation starts only from IDLE and never under a flush.
  assign issue_s = (state_q == ST_IDLE) && op_valid && is_md_s && !flush;

  // Unit result is architecturally committed unless the op is being flushed.
  assign cap_s   = (state_q == ST_BUSY) && md.md_ready && !flush;

  // HI/LO write enables and next values (capture or MTHI/MTLO).
  always_comb begin
    hi_wr_s = 1'b0;
    lo_wr_s = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cap_s) begin
      hi_wr_s = 1'b1;
      lo_wr_s = 1'b1;
      hi_d    = md.md_result[63:32];
      lo_d    = md.md_result[31:0];
    end else if ((state_q == ST_IDLE) && op_valid && !flush) begin
      if (op == OP_MTHI) begin
        hi_wr_s = 1'b1;
        hi_d    = src_a;
      end else if (op == OP_MTLO) begin
        lo_wr_s = 1'b1;
        lo_d    = src_a;
      end else begin
        hi_wr_s = 1'b0;
        lo_wr_s = 1'b0;
      end
    end else begin
      hi_wr_s = 1'b0;
      lo_wr_s = 1'b0;
    end
  end

  // Stall request: hold IF/ID/EX while the unit owns HI/LO.
  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      ST_IDLE:  stall_req = issue_s;
      // Once the result is ready the issuing op retires, so no stall here.
      ST_BUSY:  stall_req = !md.md_ready;
      ST_ABORT: stall_req = (op_valid && (is_md_s || is_mt_s)) || hilo_rd;
`ifdef HILO_FWD_EN
      // HI/LO are already final in DRAIN, so a read need not wait.
      ST_DRAIN: stall_req = op_valid && (is_md_s || is_mt_s);
`else
      ST_DRAIN: stall_req = (op_valid && (is_md_s || is_mt_s)) || hilo_rd;
`endif
      default:  stall_req = 1'b0;
    endcase
  end

  // Controller FSM with registered unit handshake and latched operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      div_q    <= 1'b0;
      signed_q <= 1'b0;
      x_q      <= 32'h0;
      y_q      <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_s) begin
            start_q  <= 1'b1;
            div_q    <= (op == OP_DIV) || (op == OP_DIVU);
            signed_q <= (op == OP_MULT) || (op == OP_DIV);
            x_q      <= src_a;
            y_q      <= src_b;
            state_q  <= ST_BUSY;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (md.md_ready) begin
            start_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else if (flush) begin
            state_q <= ST_ABORT;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_ABORT: begin
          // The unit can only be quiesced through its ready handshake.
          if (md.md_ready) begin
            start_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_ABORT;
          end
        end
        ST_DRAIN: begin
          if (!md.md_ready) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else begin
      if (hi_wr_s) begin
        hi_q <= hi_d;
      end
      if (lo_wr_s) begin
        lo_q <= lo_d;
      end
    end
  end

  assign md.md_start  = start_q;
  assign md.md_div    = div_q;
  assign md.md_signed = signed_q;
  assign md.md_x      = x_q;
  assign md.md_y      = y_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef HILO_FWD_EN
  assign hi_o = hi_wr_s ? hi_d : hi_q;
  assign lo_o = lo_wr_s ? lo_d : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl -- directed bench for md_ctrl with a behavioural
// multiply/divide unit (fixed latency, ready held until start drops).
module tb_md_ctrl;

  localparam logic [31:0] HRST = 32'h1234_5678;
  localparam int          LAT  = 8;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_rd;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  md_ctrl_if mif ();

  md_ctrl #(.HILO_RST(HRST)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_rd  (hilo_rd),
    .flush    (flush),
    .md       (mif.master),
    .stall_req(stall_req),
    .busy     (busy),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiply/divide unit ----------------
  logic        u_ready;
  logic [63:0] u_result;
  int          u_cnt;

  function automatic logic [63:0] unit_calc(input logic dv, input logic sg,
                                             input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] xs64, ys64;
    logic signed [31:0] xs, ys, q, r;
    if (!dv) begin
      if (sg) begin
        xs64 = {{32{x[31]}}, x};
        ys64 = {{32{y[31]}}, y};
        return xs64 * ys64;
      end
      return {32'h0, x} * {32'h0, y};
    end
    if (y == 32'h0) return 64'h0;
    if (sg) begin
      xs = x; ys = y;
      q = xs / ys;
      r = xs % ys;
      return {r, q};
    end
    return {x % y, x / y};
  endfunction

  always @(posedge clk) begin
    if (rst || !mif.md_start) begin
      u_ready <= 1'b0;
      u_cnt   <= 0;
    end else if (!u_ready) begin
      if (u_cnt == LAT - 1) begin
        u_ready  <= 1'b1;
        u_result <= unit_calc(mif.md_div, mif.md_signed, mif.md_x, mif.md_y);
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  assign mif.md_ready  = u_ready;
  assign mif.md_result = u_result;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one mul/div, hold it in EX until capture, then walk through DRAIN.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic ediv, input logic esg,
                        input logic [31:0] ehi, input logic [31:0] elo);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; hilo_rd = 1'b0;
    @(negedge clk);
    check("issue_stall", 32'(stall_req), 32'd1);
    check("issue_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    hilo_rd = 1'b1;
    @(negedge clk);
    check("busy", 32'(busy), 32'd1);
    check("md_start", 32'(mif.md_start), 32'd1);
    check("md_x", mif.md_x, a);
    check("md_y", mif.md_y, b);
    check("md_div", 32'(mif.md_div), 32'(ediv));
    check("md_signed", 32'(mif.md_signed), 32'(esg));
    for (int k = 0; k < 40; k++) begin
      if (mif.md_ready) break;
      check("busy_stall", 32'(stall_req), 32'd1);
      @(negedge clk);
    end
    if (!mif.md_ready) check("ready_timeout", 32'd0, 32'd1);
    check("cap_stall", 32'(stall_req), 32'd0);
`ifdef HILO_FWD_EN
    check("cap_hi_fwd", hi_o, ehi);
`else
    check("cap_hi_reg", hi_o, cur_hi);
`endif
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("hi", hi_o, ehi);
    check("lo", lo_o, elo);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_start", 32'(mif.md_start), 32'd0);
`ifdef HILO_FWD_EN
    check("drain_mf_stall", 32'(stall_req), 32'd0);
`else
    check("drain_mf_stall", 32'(stall_req), 32'd1);
`endif
    @(posedge clk); #1;
    hilo_rd = 1'b0; op_valid = 1'b1; op = OP_MULT;
    @(negedge clk);
    check("drain_op_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("post_busy", 32'(busy), 32'd0);
    check("post_start", 32'(mif.md_start), 32'd0);
    cur_hi = ehi;
    cur_lo = elo;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 3'b000; src_a = 32'h0; src_b = 32'h0;
    hilo_rd = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", hi_o, HRST);
    check("rst_lo", lo_o, HRST);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mif.md_start), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    cur_hi = HRST; cur_lo = HRST;

    // MTHI / MTLO in IDLE
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    op = OP_MTLO; src_a = 32'h0F0F_0F0F;
    @(negedge clk);
    check("mthi_hi", hi_o, 32'hA5A5_A5A5);
    check("mthi_lo", lo_o, HRST);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo_o, 32'h0F0F_0F0F);
    cur_hi = 32'hA5A5_A5A5; cur_lo = 32'h0F0F_0F0F;

    // flush in IDLE blocks MTHI and issue
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    check("flush_mt_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    op = OP_MULT;
    @(negedge clk);
    check("flush_iss_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_hi", hi_o, 32'hA5A5_A5A5);
    check("flush_busy", 32'(busy), 32'd0);

    // no-op code and MFHI in IDLE
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'b111; src_a = 32'h1111_1111; hilo_rd = 1'b1;
    @(negedge clk);
    check("noop_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; hilo_rd = 1'b0;
    @(negedge clk);
    check("noop_hi", hi_o, 32'hA5A5_A5A5);
    check("noop_lo", lo_o, 32'h0F0F_0F0F);

    run_md(OP_MULT,  32'd3, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_md(OP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md(OP_DIVU,  32'd7, 32'd2,         1'b1, 1'b0, 32'h0000_0001, 32'h0000_0003);
    run_md(OP_DIVU,  32'd5, 32'd0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);

    // flush during BUSY -> ABORT, handshake completes, HI/LO untouched
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk); #1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("abort_flush_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (mif.md_ready) break;
      check("abort_start", 32'(mif.md_start), 32'd1);
      check("abort_stall", 32'(stall_req), 32'd1);
      @(negedge clk);
    end
    check("abort_ready_start", 32'(mif.md_start), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("abort_drain_start", 32'(mif.md_start), 32'd0);
    wait_idle();
    check("abort_hi", hi_o, cur_hi);
    check("abort_lo", lo_o, cur_lo);

    run_md(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0, 32'd6);

    // flush in the same cycle as md_ready: result discarded
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (mif.md_ready) break;
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("rdyflush_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("rdyflush_hi", hi_o, 32'h0);
    check("rdyflush_lo", lo_o, 32'd6);
    check("rdyflush_busy", 32'(busy), 32'd1);
    wait_idle();

    // reset mid-operation
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_start", 32'(mif.md_start), 32'd0);
    check("mrst_x", mif.md_x, 32'h0);
    check("mrst_hi", hi_o, HRST);
    check("mrst_lo", lo_o, HRST);
    cur_hi = HRST; cur_lo = HRST;

    run_md(OP_DIVU, 32'd7, 32'd2, 1'b1, 1'b0, 32'h1, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
